// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 8-bit ALU with CCR {C,N,Z}, stack pointer, EX/MEM register.
// Define EX_FWD_EN to enable MEM/WB operand forwarding; otherwise the fwd_* inputs are ignored.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic       ex_mem_write,
  input  logic       ex_setc,
  input  logic       ex_clrc,
  input  logic       stack_push_ex,
  input  logic       stack_pop_ex,
  input  logic [3:0] ex_alu_op,
  input  logic [7:0] ex_read_data_a,
  input  logic [7:0] ex_read_data_b,
  input  logic [1:0] ex_rs,
  input  logic [1:0] ex_rt,
  input  logic [1:0] ex_reg_dist,
  input  logic [1:0] mem_src_ex,
  input  logic [2:0] wb_result_mux_ex,
  input  logic       fwd_mem_we,
  input  logic [1:0] fwd_mem_rd,
  input  logic [7:0] fwd_mem_data,
  input  logic       fwd_wb_we,
  input  logic [1:0] fwd_wb_rd,
  input  logic [7:0] fwd_wb_data,
  output logic       mem_reg_write,
  output logic       mem_mem_read,
  output logic       mem_mem_write,
  output logic [7:0] mem_alu_result,
  output logic [7:0] mem_store_data,
  output logic [7:0] mem_stack_addr,
  output logic [1:0] mem_rd,
  output logic [1:0] mem_src_mem,
  output logic [2:0] mem_wb_result_mux,
  output logic [2:0] ccr,
  output logic [7:0] sp
);

  localparam int unsigned DW   = 8;
  localparam int unsigned RW   = 2;
  localparam int unsigned MUXW = 3;
  localparam int unsigned CCRW = 3;

  localparam logic [3:0] OP_PASS_B = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_OR     = 4'h5;
  localparam logic [3:0] OP_NOT    = 4'h6;
  localparam logic [3:0] OP_INC    = 4'h7;
  localparam logic [3:0] OP_DEC    = 4'h8;
  localparam logic [3:0] OP_RLC    = 4'h9;
  localparam logic [3:0] OP_RRC    = 4'hA;
  localparam logic [3:0] OP_NEG    = 4'hB;

  localparam logic [DW-1:0] SP_RESET = 8'hFF;

  typedef struct packed {
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [DW-1:0]   alu_result;
    logic [DW-1:0]   store_data;
    logic [DW-1:0]   stack_addr;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   src_mem;
    logic [MUXW-1:0] wb_result_mux;
  } exmem_t;

  exmem_t          exmem_q, exmem_d;
  logic [CCRW-1:0] ccr_q, ccr_d;
  logic [DW-1:0]   sp_q, sp_d;

  logic [DW-1:0]   op_a, op_b;
  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic            upd_zn, upd_c;
  logic            c_q, n_q, z_q;
  logic            c_d, n_d, z_d;
  logic [DW-1:0]   stack_addr;

  assign c_q = ccr_q[2];
  assign n_q = ccr_q[1];
  assign z_q = ccr_q[0];

`ifdef EX_FWD_EN
  // MEM stage result is younger than WB, so it takes priority
  always_comb begin
    op_a = ex_read_data_a;
    op_b = ex_read_data_b;
    if (fwd_mem_we && (fwd_mem_rd == ex_rs))     op_a = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd == ex_rs))  op_a = fwd_wb_data;
    if (fwd_mem_we && (fwd_mem_rd == ex_rt))     op_b = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd == ex_rt))  op_b = fwd_wb_data;
  end
`else
  logic unused_fwd;
  assign op_a = ex_read_data_a;
  assign op_b = ex_read_data_b;
  assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_we, fwd_wb_rd, fwd_wb_data, ex_rs, ex_rt};
`endif

  // ALU: C is carry for add/inc, borrow for sub/dec/neg, shifted-out bit for rotates
  always_comb begin
    alu_res = op_a;
    alu_c   = c_q;
    upd_zn  = 1'b0;
    upd_c   = 1'b0;
    unique case (ex_alu_op)
      OP_PASS_B: alu_res = op_b;
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_c   = (op_a < op_b);
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OP_AND: begin
        alu_res = op_a & op_b;
        upd_zn  = 1'b1;
      end
      OP_OR: begin
        alu_res = op_a | op_b;
        upd_zn  = 1'b1;
      end
      OP_NOT: begin
        alu_res = ~op_a;
        upd_zn  = 1'b1;
      end
      OP_INC: begin
        {alu_c, alu_res} = {1'b0, op_a} + (DW + 1)'(1);
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      OP_DEC: begin
        alu_res = op_a - DW'(1);
        alu_c   = (op_a == '0);
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OP_RLC: begin
        alu_res = {op_a[DW-2:0], c_q};
        alu_c   = op_a[DW-1];
        upd_c   = 1'b1;
      end
      OP_RRC: begin
        alu_res = {c_q, op_a[DW-1:1]};
        alu_c   = op_a[0];
        upd_c   = 1'b1;
      end
      OP_NEG: begin
        alu_res = DW'(0) - op_a;
        alu_c   = (op_a != '0);
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      default: alu_res = op_a;
    endcase
  end

  // Flag update; explicit set/clear of carry overrides the ALU, set wins
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    if (upd_zn) begin
      z_d = (alu_res == '0);
      n_d = alu_res[DW-1];
    end
    if (upd_c) c_d = alu_c;
    if (ex_setc)      c_d = 1'b1;
    else if (ex_clrc) c_d = 1'b0;
    ccr_d = {c_d, n_d, z_d};
  end

  // Stack pointer points at the next free slot; pop addresses the slot above it
  always_comb begin
    stack_addr = sp_q;
    sp_d       = sp_q;
    if (stack_push_ex && !stack_pop_ex) begin
      sp_d = sp_q - DW'(1);
    end else if (stack_pop_ex && !stack_push_ex) begin
      stack_addr = sp_q + DW'(1);
      sp_d       = sp_q + DW'(1);
    end
  end

  always_comb begin
    exmem_d               = '0;
    exmem_d.reg_write     = ex_reg_write;
    exmem_d.mem_read      = ex_mem_read;
    exmem_d.mem_write     = ex_mem_write;
    exmem_d.alu_result    = alu_res;
    exmem_d.store_data    = op_b;
    exmem_d.stack_addr    = stack_addr;
    exmem_d.rd            = ex_reg_dist;
    exmem_d.src_mem       = mem_src_ex;
    exmem_d.wb_result_mux = wb_result_mux_ex;
  end

  // Priority: reset, stall (hold), flush (bubble, state kept), normal advance
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
      ccr_q   <= '0;
      sp_q    <= SP_RESET;
    end else if (stall) begin
      exmem_q <= exmem_q;
      ccr_q   <= ccr_q;
      sp_q    <= sp_q;
    end else if (flush) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
      ccr_q   <= ccr_d;
      sp_q    <= sp_d;
    end
  end

  assign mem_reg_write     = exmem_q.reg_write;
  assign mem_mem_read      = exmem_q.mem_read;
  assign mem_mem_write     = exmem_q.mem_write;
  assign mem_alu_result    = exmem_q.alu_result;
  assign mem_store_data    = exmem_q.store_data;
  assign mem_stack_addr    = exmem_q.stack_addr;
  assign mem_rd            = exmem_q.rd;
  assign mem_src_mem       = exmem_q.src_mem;
  assign mem_wb_result_mux = exmem_q.wb_result_mux;
  assign ccr               = ccr_q;
  assign sp                = sp_q;

endmodule
